conv_layer_seq: RTL and testbench
=================================

Name: conv_layer_seq

Overview:
- Sequences one convolution layer into the per-channel layer memory.
- For every output channel and every pixel address, requests one result from the MAC engine and issues a single-cycle store strobe with channel/address/value.
- After the last channel, drives pooling and waits for the memory's pool-complete flag, then reports layer done.
- Sits between the top-level network scheduler (start/done) and the MAC engine plus layer memory.

Parameters:
- OC, 7, index of last output channel (OC+1 channels).
- CHANNEL_SIZE, 783, last pixel address in a channel (CHANNEL_SIZE+1 pixels).
- ADDR_LEN, 9, MSB index of pixel address buses (width ADDR_LEN+1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: begin layer; sampled only in IDLE.
- abort, input, 1: synchronous abort to IDLE, any state.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at layer completion.
- mac_req, output, 1: one-cycle request for result (mac_ch, mac_addr).
- mac_ch, output, 4: channel of current request.
- mac_addr, output, ADDR_LEN+1: pixel address of current request.
- mac_valid, input, 1: result valid; honoured only in WAIT_MAC.
- mac_value, input, 8 signed: result data.
- store, output, 1: one-cycle write strobe to layer memory.
- out_c, output, 4: channel for store.
- w_addr, output, ADDR_LEN+1: address for store.
- value, output, 8 signed: registered mac_value for store.
- cout_done, output, 1: one-cycle pulse with the store of a channel's last pixel.
- pool, output, 1: pooling enable, level.
- pool_done, input, 1: pooling complete from layer memory.

Behaviour:
- Reset: state IDLE; ch=0, addr=0; all outputs 0.
- mac_ch/out_c = ch and mac_addr/w_addr = addr (registered counters).
- IDLE: start=1 loads ch=0, addr=0 and goes to ISSUE. start is ignored in all other states.
- ISSUE: mac_req=1 for exactly one cycle, then WAIT_MAC.
- WAIT_MAC: hold until mac_valid=1. That edge latches value<=mac_value and goes to STORE. mac_valid is ignored in all other states.
- STORE: store=1 for exactly one cycle.
  - If addr==CHANNEL_SIZE: cout_done=1 in the same cycle and addr<=0. Then, if ch==OC go to POOL, else ch<=ch+1 and go to ISSUE.
  - Otherwise addr<=addr+1 and go to ISSUE.
- Minimum of 3 cycles per pixel (mac_valid may be high on the cycle after mac_req). Total stores = (OC+1)*(CHANNEL_SIZE+1).
- POOL: pool=1 held.
  - When pool_done=1 is sampled: pool<=0 and go to FINISH.
  - If pool_done is already 1 on POOL entry (stale), it is treated as a completion; the upstream scheduler must not allow this.
- FINISH: done=1 for one cycle, then IDLE.
- store, mac_req and pool are mutually exclusive; never two high in the same cycle.
- abort: highest priority. Next state IDLE; store, mac_req, pool, cout_done, done forced 0 on that edge. ch/addr reset to 0. No done pulse.
- abort and start in the same IDLE cycle: abort wins; stay IDLE.
- Reset mid-operation: immediate return to reset values, including pool=0.
- Counters never exceed OC / CHANNEL_SIZE; no wrap beyond them.

Test Plan:
- OC=1, CHANNEL_SIZE=3, MAC model returns value=addr+16*ch one cycle after mac_req; pulse start → exactly 8 stores (out_c,w_addr,value) = (0,0,0)…(0,3,3),(1,0,16)…(1,3,19); cout_done with stores (0,3) and (1,3); then pool high.
- Continue: hold pool_done low 5 cycles, then high → pool drops on the sampling edge; done pulses exactly one cycle later; busy low after done.
- MAC delay 4 cycles for one pixel, mac_valid glitch while in ISSUE/STORE → glitch ignored; store occurs only after the genuine valid; no duplicate or skipped address.
- start re-asserted while busy → no restart; sequence identical to the first scenario.
- abort asserted in WAIT_MAC of (1,2) → next cycle IDLE, busy=0, no store/done; new start begins at (0,0).
- rst low during POOL → pool=0 immediately; all outputs 0; restart after release completes normally.

Source files
------------

// File: rtl/conv_layer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// conv_layer_seq: walks every (channel, pixel) of one conv layer through the MAC engine,
// stores each result into layer memory, then runs pooling and reports completion.
module conv_layer_seq #(
  parameter int OC           = 7,
  parameter int CHANNEL_SIZE = 783,
  parameter int ADDR_LEN     = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mac_req,
  output logic [3:0]          mac_ch,
  output logic [ADDR_LEN:0]   mac_addr,
  input  logic                mac_valid,
  input  logic signed [7:0]   mac_value,
  output logic                store,
  output logic [3:0]          out_c,
  output logic [ADDR_LEN:0]   w_addr,
  output logic signed [7:0]   value,
  output logic                cout_done,
  output logic                pool,
  input  logic                pool_done
);

  localparam logic [3:0]        LAST_CH   = OC[3:0];
  localparam logic [ADDR_LEN:0] LAST_ADDR = CHANNEL_SIZE[ADDR_LEN:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_STORE  = 3'd3,
    S_POOL   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              ch_q, ch_d;
  logic [ADDR_LEN:0]       addr_q, addr_d;
  logic signed [7:0]       value_q, value_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    value_d = value_q;
    if (abort) begin
      state_d = S_IDLE;
      ch_d    = '0;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ch_d    = '0;
            addr_d  = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (mac_valid) begin
            value_d = mac_value;
            state_d = S_STORE;
          end
        end
        S_STORE: begin
          // Channel wrap: last pixel either advances the channel or ends the conv pass
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (ch_q == LAST_CH) begin
              state_d = S_POOL;
            end else begin
              ch_d    = ch_q + 4'd1;
              state_d = S_ISSUE;
            end
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_POOL: begin
          if (pool_done) state_d = S_FINISH;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are pure state decodes, so they are one-hot by construction
  assign busy      = (state_q != S_IDLE);
  assign mac_req   = (state_q == S_ISSUE);
  assign store     = (state_q == S_STORE);
  assign cout_done = (state_q == S_STORE) && (addr_q == LAST_ADDR);
  assign pool      = (state_q == S_POOL);
  assign done      = (state_q == S_FINISH);
  assign mac_ch    = ch_q;
  assign out_c     = ch_q;
  assign mac_addr  = addr_q;
  assign w_addr    = addr_q;
  assign value     = value_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// tb_conv_layer_seq: directed scenarios with randomized MAC latency/data, checked against
// a store list built from the layer's nested channel/pixel loops.
module tb_conv_layer_seq;

  localparam int OC = 1;
  localparam int CS = 3;
  localparam int AL = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, mac_req, store, cout_done, pool;
  logic [3:0]        mac_ch, out_c;
  logic [AL:0]       mac_addr, w_addr;
  logic              mac_valid = 1'b0;
  logic signed [7:0] mac_value = '0;
  logic signed [7:0] value;
  logic              pool_done = 1'b0;

  conv_layer_seq #(.OC(OC), .CHANNEL_SIZE(CS), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mac_req(mac_req), .mac_ch(mac_ch), .mac_addr(mac_addr),
    .mac_valid(mac_valid), .mac_value(mac_value),
    .store(store), .out_c(out_c), .w_addr(w_addr), .value(value),
    .cout_done(cout_done), .pool(pool), .pool_done(pool_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MAC responder configuration
  int        delay_mode = 1;   // 0: random 1..4, otherwise fixed latency
  bit        glitch_en  = 1'b0;
  logic [7:0] salt      = 8'd0;

  typedef logic [22:0] rec_t;  // {cout_done, out_c, w_addr, value}
  rec_t got_q[$];
  rec_t exp_q[$];
  int   excl_viol = 0;
  int   done_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // MAC engine model: answers each request after a latency; optional spurious valids
  initial begin : g_mac_model
    bit         pending = 1'b0;
    int         cnt = 0;
    logic [3:0] pc;
    logic [AL:0] pa;
    forever begin
      @(negedge clk);
      mac_valid = 1'b0;
      mac_value = 8'($urandom);
      if (!busy) pending = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          mac_valid = 1'b1;
          mac_value = 8'(int'(pa) + 16 * int'(pc) + int'(salt));
          pending   = 1'b0;
        end
      end
      if (mac_req) begin
        pending = 1'b1;
        cnt = (delay_mode == 0) ? int'($urandom_range(1, 4)) : delay_mode;
        pc  = mac_ch;
        pa  = mac_addr;
        if (glitch_en) begin
          mac_valid = 1'b1;
          mac_value = 8'sh7f;
        end
      end else if (store && glitch_en) begin
        mac_valid = 1'b1;
        mac_value = -8'sd1;
      end
    end
  end

  initial begin : g_monitor
    forever begin
      @(negedge clk);
      if (store) got_q.push_back({cout_done, out_c, w_addr, value});
      if (int'(store) + int'(mac_req) + int'(pool) > 1) excl_viol++;
      if (done) done_cnt++;
    end
  end

  task automatic build_expected(input logic [7:0] s);
    exp_q.delete();
    for (int c = 0; c <= OC; c++)
      for (int a = 0; a <= CS; a++)
        exp_q.push_back({(a == CS), 4'(c), 10'(a), 8'(a + 16 * c + int'(s))});
  endtask

  task automatic check_stores(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_store%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic wait_pool(input string tag);
    int n = 0;
    while (!pool && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pool_reached"}, 64'(pool), 64'd1);
  endtask

  task automatic run_layer(input string tag, input logic [7:0] s, input int dm,
                           input bit gl, input bit hold_start);
    salt = s; delay_mode = dm; glitch_en = gl;
    got_q.delete();
    build_expected(s);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    wait_pool(tag);
    start = 1'b0;
    check_stores(tag);
  endtask

  task automatic finish_pool(input string tag, input int low_cycles);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < low_cycles; i++) begin
      chk($sformatf("%s_pool_hold%0d", tag, i), {62'd0, pool, done}, 64'b10);
      @(negedge clk);
    end
    pool_done = 1'b1;
    @(negedge clk);
    pool_done = 1'b0;
    chk({tag, "_pool_drop_done"}, {62'd0, pool, done}, 64'b01);
    @(negedge clk);
    chk({tag, "_after_done"}, {62'd0, busy, done}, 64'b00);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin : g_main
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, mac_req, store, cout_done, pool,
                              mac_ch, mac_addr, out_c, w_addr, value}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic layer, 1-cycle MAC latency, value = addr + 16*ch
    run_layer("basic", 8'd0, 1, 1'b0, 1'b0);
    finish_pool("basic", 5);

    // Random latency, spurious valids, start held high while busy
    run_layer("glitch", 8'd0, 0, 1'b1, 1'b1);
    finish_pool("glitch", int'($urandom_range(0, 3)));

    // Abort while waiting on the MAC for (1,2)
    salt = 8'($urandom); delay_mode = 3; glitch_en = 1'b0;
    got_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mac_req && mac_ch == 4'd1 && mac_addr == 10'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_1_2", 64'(n < 200), 64'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n = done_cnt;
    chk("abort_idle", 64'({busy, store, done, mac_req, mac_ch, mac_addr}), 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_store_count", 64'(got_q.size()), 64'd6);
    chk("abort_no_done", 64'(done_cnt - n), 64'd0);

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_same", 64'(busy), 64'd0);

    run_layer("post_abort", 8'($urandom), 0, 1'b1, 1'b0);
    finish_pool("post_abort", 2);

    // Asynchronous reset during pooling
    run_layer("pre_rst", 8'($urandom), 1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_pool", 64'({busy, done, mac_req, store, cout_done, pool,
                             mac_ch, mac_addr, out_c, w_addr, value}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_layer("post_rst", 8'($urandom), 0, 1'b1, 1'b0);
    finish_pool("post_rst", 1);

    chk("mutual_exclusion", 64'(excl_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : g_timeout
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
